print_job_queue: RTL and testbench
==================================

Name: print_job_queue

Overview:
- Job queue upstream of the colour and black printer FSMs.
- Buffers print requests from the debounced print button or scanner copy flags: one colour/black bit plus a 2-bit page count per request.
- Issues one job at a time to the matching printer, then waits for that printer's fin before issuing the next.
- Holds issue while the target channel's ink-error flag is set.

Parameters:
- DEPTH, 4, number of job entries; power of two, ≥2.
- CW, 3, count width = clog2(DEPTH+1).

Ports:
- CLK  in  1  system clock.
- reset  in  1  asynchronous, active-high; clears all state.
- enq  in  1  one-cycle request pulse (already debounced).
- enq_color  in  1  1 = colour job, 0 = black job; sampled with enq.
- enq_pages  in  2  page count 1..3; sampled with enq.
- fin_color  in  1  colour printer finished (level, ≥1 cycle).
- fin_negro  in  1  black printer finished (level, ≥1 cycle).
- err_color  in  1  colour ink empty (level).
- err_negro  in  1  black ink empty (level).
- start_color  out  1  one-cycle start pulse to the colour printer.
- start_negro  out  1  one-cycle start pulse to the black printer.
- pages_out  out  2  page count of the active job; valid from start pulse until the job ends.
- busy  out  1  a job is active (ISSUE, WAIT_FIN or WAIT_CLR).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  CW  stored entries, excluding the active job.
- drop  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Storage
  - Circular buffer of DEPTH entries, 3 bits each: {color, pages}.
  - wr_ptr and rd_ptr each log2(DEPTH) bits and wrap naturally.
  - count is held explicitly.
- Reset values
  - Pointers = 0, count = 0, state = IDLE, active_color = 0.
  - All outputs 0 except empty = 1.
- Enqueue
  - On enq with enq_pages != 0 and not full, write the entry at wr_ptr on the clock edge; wr_ptr++ and count++.
  - enq with enq_pages == 0, or enq while full, does not write; drop = 1 on the next cycle.
  - Exception: full with a same-cycle pop is accepted (see Simultaneous).
- FSM states: IDLE, ISSUE, WAIT_FIN, WAIT_CLR.
- IDLE
  - Leaves only when !empty and the err for the head entry's channel is 0.
  - On exit: pop the head into active_color / pages_out registers, rd_ptr++, count--, go to ISSUE.
  - If the head's channel has err = 1: remain in IDLE; the head is not skipped and no reordering occurs.
- ISSUE (exactly one cycle)
  - start_color = active_color; start_negro = ~active_color.
  - Go to WAIT_FIN.
  - Latency: job stored at edge N, queue empty, IDLE, no err → pop at edge N+1, start pulse high during cycle N+1..N+2.
- WAIT_FIN
  - Stay until fin of the active channel is 1, then go to WAIT_CLR.
  - The other channel's fin is ignored.
- WAIT_CLR
  - Stay until fin of the active channel is 0, then go to IDLE and clear busy.
  - Prevents a long fin level from ending two jobs.
- Held outputs
  - pages_out and active_color stay constant from ISSUE through WAIT_CLR.
  - pages_out = 0 in IDLE.
- Simultaneous events
  - enq and pop on the same edge: count unchanged, both pointers advance.
  - When full, this case is accepted with no drop.
  - Enqueue into an empty queue cannot pop the same entry in the same cycle; the pop occurs on the following edge.
- Errors during a job
  - err rising during WAIT_FIN/WAIT_CLR does not abort the job; the printer handles it.
  - The queue only gates new issues.
- Reset mid-job
  - Immediate return to reset values; any in-flight start pulse is cut.
  - Queued jobs are discarded.
- busy = (state != IDLE); full/empty are combinational from count.

Test Plan:
- Single job: enq with color=1, pages=2 → start_color pulses 1 cycle, start_negro stays 0, pages_out=2. fin_color high 3 cycles then low → busy falls one cycle after fin drops; count=0.
- Fill/overflow (DEPTH=4), printer busy: 5 enq pulses → count=4, full=1, drop pulses once on the 5th. 4 subsequent fin handshakes drain entries in FIFO order (pages 1,2,3,1 as enqueued).
- Invalid pages: enq with pages=0 → drop=1 for one cycle, count unchanged, no start pulse.
- Error gating: err_negro=1, head is a black job → no start for 20 cycles. err_negro→0 → start_negro pulse within 2 cycles.
- Full with simultaneous pop: queue full, IDLE, enq on the pop edge → count stays 4, drop=0, the new entry is issued last.
- Reset mid-WAIT_FIN with 2 jobs queued: reset pulse → busy=0, count=0, empty=1, pages_out=0. No start pulses until a new enq.

Source files
------------

// File: rtl/print_job_queue_if.sv
// print_job_queue_if: request, printer handshake and status bundle for the print job queue.
interface print_job_queue_if #(parameter int CW = 3);
   logic          enq;
   logic          enq_color;
   logic [1:0]    enq_pages;
   logic          fin_color;
   logic          fin_negro;
   logic          err_color;
   logic          err_negro;
   logic          start_color;
   logic          start_negro;
   logic [1:0]    pages_out;
   logic          busy;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic          drop;
   modport master (
      output enq, enq_color, enq_pages, fin_color, fin_negro, err_color, err_negro,
      input  start_color, start_negro, pages_out, busy, full, empty, count, drop
   );
   modport slave (
      input  enq, enq_color, enq_pages, fin_color, fin_negro, err_color, err_negro,
      output start_color, start_negro, pages_out, busy, full, empty, count, drop
   );
endinterface

// File: rtl/print_job_queue.sv
// print_job_queue: FIFO of {color, pages} print jobs issued one at a time to the
// colour or black printer, gated by that channel's ink error and fin handshake.
module print_job_queue #(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input logic             CLK,
   input logic             reset,
   print_job_queue_if.slave q
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_FIN, WAIT_CLR} state_t;
   state_t        state_q;
   logic [2:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          active_color_q, start_color_q, start_negro_q, drop_q;
   logic [1:0]    pages_q;
   logic [2:0]    head;
   logic          full, head_err, fin_act, pop, push;
   assign head     = mem_q[rd_ptr_q];
   assign full     = count_q == CW'(DEPTH);
   assign head_err = head[2] ? q.err_color : q.err_negro;
   assign fin_act  = active_color_q ? q.fin_color : q.fin_negro;
   // The head is never skipped: an ink error on its channel stalls the whole queue.
   assign pop      = state_q == IDLE && count_q != '0 && !head_err;
   assign push     = q.enq && q.enq_pages != 2'd0 && (!full || pop);
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
   end
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         drop_q   <= 1'b0;
      end else begin
         if (push) mem_q[wr_ptr_q] <= {q.enq_color, q.enq_pages};
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         drop_q   <= q.enq && !push;
      end
   end
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         active_color_q <= 1'b0;
         pages_q        <= 2'd0;
         start_color_q  <= 1'b0;
         start_negro_q  <= 1'b0;
      end else begin
         start_color_q <= 1'b0;
         start_negro_q <= 1'b0;
         case (state_q)
            IDLE: if (pop) begin
               state_q        <= ISSUE;
               active_color_q <= head[2];
               pages_q        <= head[1:0];
               start_color_q  <= head[2];
               start_negro_q  <= !head[2];
            end
            ISSUE:    state_q <= WAIT_FIN;
            WAIT_FIN: if (fin_act) state_q <= WAIT_CLR;
            // Waiting for fin to drop keeps one long fin level from ending two jobs.
            WAIT_CLR: if (!fin_act) begin
               state_q <= IDLE;
               pages_q <= 2'd0;
            end
         endcase
      end
   end
   assign q.start_color = start_color_q;
   assign q.start_negro = start_negro_q;
   assign q.pages_out   = pages_q;
   assign q.busy        = state_q != IDLE;
   assign q.full        = full;
   assign q.empty       = count_q == '0;
   assign q.count       = count_q;
   assign q.drop        = drop_q;
endmodule

// File: tb/tb_print_job_queue.sv
// tb_print_job_queue: directed stimulus with a start-pulse scoreboard for print_job_queue.
module tb_print_job_queue;
   typedef struct packed {logic c; logic [1:0] p;} job_t;
   logic CLK, reset;
   int   total, bad, n_starts;
   job_t exp_q[$];
   print_job_queue_if #(.CW(3)) bus();
   print_job_queue #(.DEPTH(4), .CW(3)) dut (.CLK(CLK), .reset(reset), .q(bus.slave));
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end
   function automatic void chk(input string n, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", n, got, want, $time);
      end
   endfunction
   // Monitor: every start pulse must match the oldest expected job.
   always @(negedge CLK) begin
      if (!reset && (bus.start_color || bus.start_negro)) begin
         n_starts++;
         if (exp_q.size() == 0) chk("unexpected_start", 1, 0);
         else begin
            job_t e;
            e = exp_q.pop_front();
            chk("start_color", int'(bus.start_color), int'(e.c));
            chk("start_negro", int'(bus.start_negro), int'(!e.c));
            chk("pages_out", int'(bus.pages_out), int'(e.p));
         end
      end
   end
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask
   task automatic enq_job(input logic c, input logic [1:0] p);
      bus.enq = 1'b1;
      bus.enq_color = c;
      bus.enq_pages = p;
      tick();
      bus.enq = 1'b0;
   endtask
   task automatic wait_start(input int k, output logic c);
      logic hit;
      hit = 1'b0;
      c = 1'b0;
      for (int i = 0; i < k && !hit; i++) begin
         @(posedge CLK);
         #2;
         if (bus.start_color || bus.start_negro) begin
            hit = 1'b1;
            c = bus.start_color;
         end
      end
      chk("start_seen", int'(hit), 1);
   endtask
   // Called during the ISSUE cycle: hold the active channel's fin 3 cycles, then release.
   task automatic finish_job(input logic c);
      tick();
      if (c) bus.fin_color = 1'b1; else bus.fin_negro = 1'b1;
      repeat (3) tick();
      chk("busy_during_fin", int'(bus.busy), 1);
      bus.fin_color = 1'b0;
      bus.fin_negro = 1'b0;
      tick();
      chk("busy_after_fin", int'(bus.busy), 0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end
   initial begin
      logic c;
      int   s0;
      total = 0; bad = 0; n_starts = 0;
      reset = 1'b1;
      bus.enq = 0; bus.enq_color = 0; bus.enq_pages = 0;
      bus.fin_color = 0; bus.fin_negro = 0; bus.err_color = 0; bus.err_negro = 0;
      repeat (2) tick();
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_empty", int'(bus.empty), 1);
      chk("rst_full", int'(bus.full), 0);
      chk("rst_count", int'(bus.count), 0);
      chk("rst_pages", int'(bus.pages_out), 0);
      chk("rst_drop", int'(bus.drop), 0);
      reset = 1'b0;
      tick();
      // Single colour job, 2 pages
      exp_q.push_back('{1'b1, 2'd2});
      enq_job(1'b1, 2'd2);
      chk("single_count", int'(bus.count), 1);
      wait_start(3, c);
      chk("single_color", int'(c), 1);
      tick();
      chk("single_pages_held", int'(bus.pages_out), 2);
      bus.fin_color = 1'b1;
      repeat (3) tick();
      chk("single_pages_wclr", int'(bus.pages_out), 2);
      bus.fin_color = 1'b0;
      chk("single_busy_hold", int'(bus.busy), 1);
      tick();
      chk("single_busy_fall", int'(bus.busy), 0);
      chk("single_count_end", int'(bus.count), 0);
      chk("single_pages_idle", int'(bus.pages_out), 0);
      // Invalid page count
      s0 = n_starts;
      enq_job(1'b1, 2'd0);
      chk("inv_drop", int'(bus.drop), 1);
      chk("inv_count", int'(bus.count), 0);
      tick();
      chk("inv_drop_clr", int'(bus.drop), 0);
      repeat (4) tick();
      chk("inv_no_start", n_starts, s0);
      // Fill/overflow behind an active black job, other channel's fin ignored
      exp_q.push_back('{1'b0, 2'd3});
      enq_job(1'b0, 2'd3);
      wait_start(3, c);
      tick(); tick();
      bus.fin_color = 1'b1;
      tick(); tick();
      chk("other_fin_busy", int'(bus.busy), 1);
      bus.fin_color = 1'b0;
      exp_q.push_back('{1'b1, 2'd1}); enq_job(1'b1, 2'd1);
      exp_q.push_back('{1'b0, 2'd2}); enq_job(1'b0, 2'd2);
      exp_q.push_back('{1'b1, 2'd3}); enq_job(1'b1, 2'd3);
      exp_q.push_back('{1'b0, 2'd1}); enq_job(1'b0, 2'd1);
      chk("fill_drop_none", int'(bus.drop), 0);
      enq_job(1'b1, 2'd2);
      chk("fill_drop", int'(bus.drop), 1);
      chk("fill_count", int'(bus.count), 4);
      chk("fill_full", int'(bus.full), 1);
      tick();
      chk("fill_drop_once", int'(bus.drop), 0);
      bus.fin_negro = 1'b1;
      repeat (2) tick();
      bus.fin_negro = 1'b0;
      tick();
      chk("fill_first_done", int'(bus.busy), 0);
      for (int i = 0; i < 4; i++) begin
         wait_start(4, c);
         finish_job(c);
      end
      chk("drain_empty", int'(bus.empty), 1);
      // Error gating on the head's channel
      bus.err_negro = 1'b1;
      s0 = n_starts;
      exp_q.push_back('{1'b0, 2'd2});
      enq_job(1'b0, 2'd2);
      repeat (20) tick();
      chk("err_no_start", n_starts, s0);
      chk("err_count", int'(bus.count), 1);
      bus.err_negro = 1'b0;
      wait_start(2, c);
      chk("err_release_black", int'(c), 0);
      finish_job(c);
      // Full queue held by errors, then enqueue on the pop edge
      bus.err_color = 1'b1;
      bus.err_negro = 1'b1;
      s0 = n_starts;
      exp_q.push_back('{1'b1, 2'd3}); enq_job(1'b1, 2'd3);
      exp_q.push_back('{1'b0, 2'd1}); enq_job(1'b0, 2'd1);
      exp_q.push_back('{1'b1, 2'd2}); enq_job(1'b1, 2'd2);
      exp_q.push_back('{1'b0, 2'd2}); enq_job(1'b0, 2'd2);
      tick();
      chk("sim_full", int'(bus.full), 1);
      chk("sim_held", n_starts, s0);
      bus.err_color = 1'b0;
      bus.err_negro = 1'b0;
      exp_q.push_back('{1'b0, 2'd3});
      enq_job(1'b0, 2'd3);
      chk("sim_count", int'(bus.count), 4);
      chk("sim_drop", int'(bus.drop), 0);
      chk("sim_start", int'(bus.start_color), 1);
      finish_job(1'b1);
      for (int i = 0; i < 4; i++) begin
         wait_start(4, c);
         finish_job(c);
      end
      chk("sim_sb_empty", exp_q.size(), 0);
      // Reset mid-WAIT_FIN with two jobs queued
      exp_q.push_back('{1'b1, 2'd1});
      enq_job(1'b1, 2'd1);
      wait_start(3, c);
      tick(); tick();
      enq_job(1'b0, 2'd2);
      enq_job(1'b1, 2'd3);
      chk("mid_count", int'(bus.count), 2);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_busy", int'(bus.busy), 0);
      chk("mid_rst_count", int'(bus.count), 0);
      chk("mid_rst_empty", int'(bus.empty), 1);
      chk("mid_rst_pages", int'(bus.pages_out), 0);
      @(posedge CLK);
      #3;
      reset = 1'b0;
      s0 = n_starts;
      repeat (10) tick();
      chk("mid_no_start", n_starts, s0);
      exp_q.push_back('{1'b0, 2'd1});
      enq_job(1'b0, 2'd1);
      wait_start(3, c);
      finish_job(c);
      tick();
      chk("final_sb_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
